// File: rtl/or_gate_checker_if.sv
// Stimulus and result bundle between an OR-gate checker and whatever drives it.
interface or_gate_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             sample_valid;
  logic             A;
  logic             B;
  logic             Y;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             error;
  logic [2:0]       first_fail;
  logic [3:0]       cov;
  logic             all_cov;

  // Stimulus side: drives control and sampled vectors, observes results.
  modport master (
    output start, stop, sample_valid, A, B, Y,
    input  busy, done, pass_cnt, fail_cnt, error, first_fail, cov, all_cov
  );

  // Checker side: consumes control and vectors, produces results.
  modport slave (
    input  start, stop, sample_valid, A, B, Y,
    output busy, done, pass_cnt, fail_cnt, error, first_fail, cov, all_cov
  );
endinterface

// File: rtl/or_gate_checker.sv
// Session-based checker for a 2-input OR gate: counts matching and
// mismatching samples, records the first failure and tracks input coverage.
module or_gate_checker #(
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  or_gate_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic             start_acc;
  logic             accept;
  logic             match;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             error;
  logic [2:0]       first_fail;
  logic [3:0]       cov;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus session-clear and sample-accept strobes.
  // Start is only honoured outside RUN; inside RUN stop has priority.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          start_acc = 1'b1;
        end
      end
      RUN: begin
        accept = bus.sample_valid;
        if (bus.stop) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          start_acc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Expected OR output compared against the observed Y.
  assign match = (bus.Y == (bus.A | bus.B));

  // Result registers: cleared by reset or an accepted start, updated per accepted sample.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      error      <= 1'b0;
      first_fail <= 3'b000;
      cov        <= 4'b0000;
    end else if (accept) begin
      cov[{bus.A, bus.B}] <= 1'b1;
      if (match) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
        if (!error) first_fail <= {bus.A, bus.B, bus.Y};
        error <= 1'b1;
      end
    end
  end

  // Status decoded from the registered state; results straight from their flops.
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.pass_cnt   = pass_cnt;
  assign bus.fail_cnt   = fail_cnt;
  assign bus.error      = error;
  assign bus.first_fail = first_fail;
  assign bus.cov        = cov;
  assign bus.all_cov    = &cov;

endmodule
